multiport_memory_controller: RTL and testbench

//   Parametrised PDP-8 main memory with NUM_PORTS requesters (CPU, DMA, front panel) on one shared array.

---
 rtl/multiport_memory_controller.sv | 217 +++++++++++++++++++++
 tb/tb_multiport_memory_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_memory_controller.sv
// ---------------------------------------------------------------------------
// multiport_memory_controller
//
// PDP-8 main memory shared by NUM_PORTS requesters (port 0 = CPU, others DMA,
// front panel, ...). A round-robin arbiter accepts one request at a time.
// The accepted access spends LATENCY cycles in ACCESS, commits on the last
// of them, and is reported by a one-cycle done pulse. Every word carries a
// valid bit. Reads of never-written words return zero, are flagged and are
// counted. Addresses at or above DEPTH are flagged as errors and have no
// effect on the array.
//
// Ports
//   clk           sole clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   req_valid     per-port request
//   req_write     per-port: 1 = write, 0 = read
//   req_ifetch    per-port: instruction fetch (behaves as a data read)
//   req_addr      packed addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata     packed write data, port p at [p*WORD_WIDTH +: WORD_WIDTH]
//   grant         one-hot, one-cycle pulse: request accepted
//   done          one-hot, one-cycle pulse: access complete
//   rdata         read result, valid with done, held until the next read
//   rdata_uninit  with done: the word read had never been written
//   err           with done: address was >= DEPTH
//   busy          controller is not idle
//   uninit_reads  saturating count of uninitialised reads
// ---------------------------------------------------------------------------
module multiport_memory_controller #(
    parameter int WORD_WIDTH = 12,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096,
    parameter int NUM_PORTS  = 2,
    parameter int LATENCY    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS-1:0]            req_ifetch,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*WORD_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            grant,
    output logic [NUM_PORTS-1:0]            done,
    output logic [WORD_WIDTH-1:0]           rdata,
    output logic                            rdata_uninit,
    output logic                            err,
    output logic                            busy,
    output logic [15:0]                     uninit_reads
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0]         LAST_CNT    = CW'(LATENCY - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [PW-1:0]         LAST_PORT   = PW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [WORD_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DEPTH-1:0]      valid_bits;

    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         arb_port;
    logic                  arb_found;

    logic [PW-1:0]         cur_port;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_write;
    logic [WORD_WIDTH-1:0] cur_wdata;
    logic [CW-1:0]         lat_cnt;

    logic [WORD_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  uninit_q;
    logic [15:0]           uninit_cnt;

    logic                  in_range;
    logic [IW-1:0]         cur_idx;
    logic                  access_fire;
    logic                  unused_ifetch;

    // Instruction fetches and data reads are serviced identically; the fetch
    // flag is accepted only so the bus interface matches the CPU side.
    assign unused_ifetch = ^req_ifetch;

    assign in_range    = ({1'b0, cur_addr} < DEPTH_LIMIT);
    assign cur_idx     = cur_addr[IW-1:0];
    assign access_fire = (state == S_ACCESS) && (lat_cnt == LAST_CNT);

    // Round-robin search starting at rr_ptr and wrapping; first requester wins.
    always_comb begin
        arb_found = 1'b0;
        arb_port  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            int          cand;
            logic [PW-1:0] cand_idx;
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            cand_idx = PW'(cand);
            if (!arb_found && req_valid[cand_idx]) begin
                arb_found = 1'b1;
                arb_port  = cand_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (arb_found) next_state = S_ACCESS;
            S_ACCESS: if (lat_cnt == LAST_CNT) next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Outputs. Flags are registered at commit but only shown during DONE so
    // they appear strictly alongside the done pulse.
    always_comb begin
        grant        = '0;
        done         = '0;
        busy         = (state != S_IDLE);
        err          = (state == S_DONE) && err_q;
        rdata_uninit = (state == S_DONE) && uninit_q;
        rdata        = rdata_q;
        uninit_reads = uninit_cnt;
        if (state == S_IDLE && arb_found && !rst) begin
            grant[arb_port] = 1'b1;
        end
        if (state == S_DONE) begin
            done[cur_port] = 1'b1;
        end
    end

    // Request capture, latency counting and commit of the read side and the
    // bookkeeping state. A reset during ACCESS simply drops the transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            cur_port   <= '0;
            cur_addr   <= '0;
            cur_write  <= 1'b0;
            cur_wdata  <= '0;
            lat_cnt    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            uninit_q   <= 1'b0;
            uninit_cnt <= '0;
            valid_bits <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        cur_port  <= arb_port;
                        cur_addr  <= req_addr[arb_port*ADDR_WIDTH +: ADDR_WIDTH];
                        cur_write <= req_write[arb_port];
                        cur_wdata <= req_wdata[arb_port*WORD_WIDTH +: WORD_WIDTH];
                        lat_cnt   <= '0;
                        rr_ptr    <= (arb_port == LAST_PORT) ? '0 : arb_port + 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (lat_cnt != LAST_CNT) begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end else begin
                        err_q    <= !in_range;
                        uninit_q <= 1'b0;
                        if (!in_range) begin
                            if (!cur_write) begin
                                rdata_q <= '0;
                            end
                        end else if (cur_write) begin
                            valid_bits[cur_idx] <= 1'b1;
                        end else if (valid_bits[cur_idx]) begin
                            rdata_q <= mem[cur_idx];
                        end else begin
                            rdata_q  <= '0;
                            uninit_q <= 1'b1;
                            if (uninit_cnt != 16'hFFFF) begin
                                uninit_cnt <= uninit_cnt + 16'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Backing store: kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && access_fire && cur_write && in_range) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

endmodule

// File: tb/tb_multiport_memory_controller.sv
// ---------------------------------------------------------------------------
// tb_multiport_memory_controller
//
// Directed bench for a three-port, 1024-word, three-cycle-latency controller.
// Covers reset values, uninitialised and initialised reads, fetch versus
// data read, out-of-range accesses, the DEPTH boundary, reset during an
// access, round-robin fairness and counter saturation.
// ---------------------------------------------------------------------------
module tb_multiport_memory_controller;

    localparam int NP = 3;
    localparam int AW = 12;
    localparam int WW = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req_valid;
    logic [NP-1:0]     req_write;
    logic [NP-1:0]     req_ifetch;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*WW-1:0]  req_wdata;
    logic [NP-1:0]     grant;
    logic [NP-1:0]     done;
    logic [WW-1:0]     rdata;
    logic              rdata_uninit;
    logic              err;
    logic              busy;
    logic [15:0]       uninit_reads;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    multiport_memory_controller #(
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW),
        .DEPTH      (1024),
        .NUM_PORTS  (NP),
        .LATENCY    (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_ifetch   (req_ifetch),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .grant        (grant),
        .done         (done),
        .rdata        (rdata),
        .rdata_uninit (rdata_uninit),
        .err          (err),
        .busy         (busy),
        .uninit_reads (uninit_reads)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request on port p and hold it until its done pulse. Returns
    // grant-to-done latency, busy cycles seen after grant, and the outputs
    // observed in the done cycle.
    task automatic apply_stimulus(input int p, input logic wr, input logic ifc,
                                  input logic [11:0] a, input logic [11:0] d,
                                  output int lat, output int bcnt, output logic [2:0] dv,
                                  output logic [11:0] rd, output logic ue, output logic er);
        int n;
        int gc;
        @(negedge clk);
        req_write[p]           = wr;
        req_ifetch[p]          = ifc;
        req_addr[p*AW +: AW]   = a;
        req_wdata[p*WW +: WW]  = d;
        req_valid[p]           = 1'b1;
        #1;
        n = 0;
        while (grant[p] !== 1'b1 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        gc   = cyc;
        bcnt = 0;
        n    = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
            if (busy === 1'b1) bcnt++;
        end while (done[p] !== 1'b1 && n < 30);
        lat = cyc - gc;
        dv  = done;
        rd  = rdata;
        ue  = rdata_uninit;
        er  = err;
        req_valid[p] = 1'b0;
    endtask

    initial begin
        int         lat;
        int         bcnt;
        logic [2:0] dv;
        logic [11:0] rd;
        logic       ue;
        logic       er;
        int         gorder[$];
        int         dones;
        int         n;
        int         seen;

        rst        = 1'b1;
        req_valid  = '0;
        req_write  = '0;
        req_ifetch = '0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("reset_busy",   32'(busy), 32'd0);
        check_output("reset_grant",  32'(grant), 32'd0);
        check_output("reset_done",   32'(done), 32'd0);
        check_output("reset_rdata",  32'(rdata), 32'd0);
        check_output("reset_err",    32'(err), 32'd0);
        check_output("reset_uninit", 32'(rdata_uninit), 32'd0);
        check_output("reset_count",  32'(uninit_reads), 32'd0);

        $display("[TB] uninitialised read and latency");
        apply_stimulus(0, 1'b0, 1'b0, 12'h010, 12'h000, lat, bcnt, dv, rd, ue, er);
        check_output("rd_uninit_latency", lat, 32'd4);
        check_output("rd_uninit_busy",    bcnt, 32'd4);
        check_output("rd_uninit_done",    32'(dv), 32'h1);
        check_output("rd_uninit_rdata",   32'(rd), 32'd0);
        check_output("rd_uninit_flag",    32'(ue), 32'd1);
        check_output("rd_uninit_err",     32'(er), 32'd0);
        check_output("rd_uninit_count",   32'(uninit_reads), 32'd1);

        $display("[TB] write then fetch");
        apply_stimulus(0, 1'b1, 1'b0, 12'h010, 12'o7402, lat, bcnt, dv, rd, ue, er);
        check_output("wr_latency",  lat, 32'd4);
        check_output("wr_rdata",    32'(rd), 32'd0);
        check_output("wr_uninit",   32'(ue), 32'd0);
        check_output("wr_err",      32'(er), 32'd0);
        apply_stimulus(0, 1'b0, 1'b1, 12'h010, 12'h000, lat, bcnt, dv, rd, ue, er);
        check_output("fetch_rdata",  32'(rd), 32'(12'o7402));
        check_output("fetch_uninit", 32'(ue), 32'd0);
        check_output("fetch_err",    32'(er), 32'd0);
        check_output("fetch_count",  32'(uninit_reads), 32'd1);
        apply_stimulus(1, 1'b0, 1'b0, 12'h010, 12'h000, lat, bcnt, dv, rd, ue, er);
        check_output("p1_read_done",  32'(dv), 32'h2);
        check_output("p1_read_rdata", 32'(rd), 32'(12'o7402));

        $display("[TB] out-of-range and boundary");
        apply_stimulus(0, 1'b1, 1'b0, 12'h400, 12'o1234, lat, bcnt, dv, rd, ue, er);
        check_output("oor_wr_err",    32'(er), 32'd1);
        check_output("oor_wr_uninit", 32'(ue), 32'd0);
        check_output("oor_wr_rdata",  32'(rd), 32'(12'o7402));
        @(negedge clk);
        #1;
        check_output("err_after_done", 32'(err), 32'd0);
        apply_stimulus(0, 1'b0, 1'b0, 12'h000, 12'h000, lat, bcnt, dv, rd, ue, er);
        check_output("alias_rdata",  32'(rd), 32'd0);
        check_output("alias_uninit", 32'(ue), 32'd1);
        check_output("alias_err",    32'(er), 32'd0);
        check_output("alias_count",  32'(uninit_reads), 32'd2);
        apply_stimulus(2, 1'b0, 1'b0, 12'h400, 12'h000, lat, bcnt, dv, rd, ue, er);
        check_output("oor_rd_done",   32'(dv), 32'h4);
        check_output("oor_rd_rdata",  32'(rd), 32'd0);
        check_output("oor_rd_err",    32'(er), 32'd1);
        check_output("oor_rd_uninit", 32'(ue), 32'd0);
        check_output("oor_rd_count",  32'(uninit_reads), 32'd2);
        apply_stimulus(0, 1'b1, 1'b0, 12'h3FF, 12'o0777, lat, bcnt, dv, rd, ue, er);
        check_output("top_wr_err", 32'(er), 32'd0);
        apply_stimulus(0, 1'b0, 1'b0, 12'h3FF, 12'h000, lat, bcnt, dv, rd, ue, er);
        check_output("top_rd_rdata", 32'(rd), 32'(12'o0777));
        check_output("top_rd_err",   32'(er), 32'd0);

        $display("[TB] reset during access");
        @(negedge clk);
        req_write[0]      = 1'b1;
        req_addr[0 +: AW] = 12'h020;
        req_wdata[0 +: WW] = 12'o5555;
        req_valid[0]      = 1'b1;
        #1;
        check_output("rst_mid_grant", 32'(grant), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        req_write = '0;
        #1;
        check_output("rst_mid_busy",  32'(busy), 32'd0);
        check_output("rst_mid_count", 32'(uninit_reads), 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (done !== 3'b000) seen = 1;
        end
        check_output("rst_mid_no_done", seen, 32'd0);

        $display("[TB] round-robin fairness");
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            req_write[p]        = 1'b0;
            req_ifetch[p]       = 1'b0;
            req_addr[p*AW +: AW] = 12'h020;
        end
        req_valid = 3'b111;
        dones = 0;
        n     = 0;
        while (n < 80) begin
            #1;
            for (int p = 0; p < NP; p++) begin
                if (grant[p] === 1'b1) gorder.push_back(p);
            end
            if (done !== 3'b000) dones++;
            if (dones >= 6) break;
            @(negedge clk);
            n++;
        end
        req_valid = '0;
        check_output("rr_grant_count", gorder.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_output($sformatf("rr_grant_%0d", i),
                         (i < gorder.size()) ? gorder[i] : 99, i % 3);
        end
        check_output("rr_count", 32'(uninit_reads), 32'd6);
        apply_stimulus(0, 1'b0, 1'b0, 12'h020, 12'h000, lat, bcnt, dv, rd, ue, er);
        check_output("aborted_wr_uninit", 32'(ue), 32'd1);
        check_output("aborted_wr_rdata",  32'(rd), 32'd0);
        check_output("aborted_wr_count",  32'(uninit_reads), 32'd7);

        $display("[TB] counter saturation");
        @(negedge clk);
        force dut.uninit_cnt = 16'hFFFE;
        #1;
        release dut.uninit_cnt;
        apply_stimulus(1, 1'b0, 1'b0, 12'h030, 12'h000, lat, bcnt, dv, rd, ue, er);
        check_output("sat_first_uninit", 32'(ue), 32'd1);
        check_output("sat_first_count",  32'(uninit_reads), 32'h0000FFFF);
        apply_stimulus(2, 1'b0, 1'b0, 12'h031, 12'h000, lat, bcnt, dv, rd, ue, er);
        check_output("sat_second_uninit", 32'(ue), 32'd1);
        check_output("sat_second_count",  32'(uninit_reads), 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
